// File: rtl/uram_pkg.sv
// Shared definitions for the banked wide-row URAM writer.
//   URAM_WIDTH  - native width of one URAM primitive
//   wr_state_e  - write-side FSM states
//   uram_count  - number of URAM primitives needed to hold one row
package uram_pkg;

    localparam int URAM_WIDTH = 72;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2
    } wr_state_e;

    // Rows are stored across side-by-side primitives, so round up.
    function automatic int uram_count(input int data_len);
        return (data_len + URAM_WIDTH - 1) / URAM_WIDTH;
    endfunction

endpackage

// File: rtl/uram_wide_banked_if.sv
// Bus bundle for uram_wide_banked.
//   Write control : wr_start, wr_bank, wr_base_addr
//   Write beats   : din, din_valid, din_last, din_ready
//   Write status  : wr_busy, wr_done, wr_overflow, wr_rows
//   Read request  : rd_en, rd_bank, rd_addr, rd_ready
//   Read result   : dout, dout_valid
//
// Handshake rule (both din and rd): a transfer happens on a rising clock
// edge where the producer's valid (din_valid / rd_en) and the consumer's
// ready (din_ready / rd_ready) are both 1. The producer holds its payload
// stable while valid is high and ready is low; ready may depend on the
// request fields (rd_ready looks at rd_bank) but never on valid.
interface uram_wide_banked_if #(
    parameter int ADDR_LEN  = 9,
    parameter int DATA_LEN  = 144,
    parameter int DIN_LEN   = 8,
    parameter int NUM_BANKS = 2
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic                  wr_start;
    logic [BANK_W-1:0]     wr_bank;
    logic [ADDR_LEN-1:0]   wr_base_addr;
    logic [DIN_LEN-1:0]    din;
    logic                  din_valid;
    logic                  din_ready;
    logic                  din_last;
    logic                  wr_busy;
    logic                  wr_done;
    logic                  wr_overflow;
    logic [ADDR_LEN:0]     wr_rows;
    logic                  rd_en;
    logic                  rd_ready;
    logic [BANK_W-1:0]     rd_bank;
    logic [ADDR_LEN-1:0]   rd_addr;
    logic [DATA_LEN-1:0]   dout;
    logic                  dout_valid;

    modport master (
        output wr_start, wr_bank, wr_base_addr, din, din_valid, din_last,
               rd_en, rd_bank, rd_addr,
        input  din_ready, wr_busy, wr_done, wr_overflow, wr_rows,
               rd_ready, dout, dout_valid
    );

    modport slave (
        input  wr_start, wr_bank, wr_base_addr, din, din_valid, din_last,
               rd_en, rd_bank, rd_addr,
        output din_ready, wr_busy, wr_done, wr_overflow, wr_rows,
               rd_ready, dout, dout_valid
    );

endinterface

// File: rtl/uram.sv
// Single URAM primitive model: one write port, one read port with a
// registered output (one cycle from read enable to rdata_o). Contents are
// not reset, matching the physical block.
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write row address
//   wdata_i  - write data
//   re_i     - read enable; rdata_o holds while low
//   raddr_i  - read row address
//   rdata_o  - registered read data
module uram
    import uram_pkg::*;
#(
    parameter int ADDR_LEN = 12,
    parameter int WIDTH    = URAM_WIDTH
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [ADDR_LEN-1:0] waddr_i,
    input  logic [WIDTH-1:0]    wdata_i,
    input  logic                re_i,
    input  logic [ADDR_LEN-1:0] raddr_i,
    output logic [WIDTH-1:0]    rdata_o
);

    logic [WIDTH-1:0] mem_q [0:(1<<ADDR_LEN)-1];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uram_wide_banked.sv
// Banked wide-row memory fed by a narrow write stream.
// Narrow beats are packed LSB-first into a row buffer; a full row (or the
// final beat of a burst) is committed to the selected bank in one cycle,
// then the write address advances. Each bank is a row of URAM primitives
// side by side. Reads are independent, 2-cycle latency, and only stall
// while the same bank is being committed.
//   clk, rst_n   - clock, asynchronous active-low reset
//   bus          - uram_wide_banked_if slave (write/read channels, status)
//   dbg_state_o  - current write FSM state
module uram_wide_banked
    import uram_pkg::*;
#(
    parameter int ADDR_LEN  = 9,
    parameter int DATA_LEN  = 144,
    parameter int DIN_LEN   = 8,
    parameter int NUM_BANKS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uram_wide_banked_if.slave     bus,
    output wr_state_e             dbg_state_o
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int BEATS  = DATA_LEN / DIN_LEN;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NU     = uram_count(DATA_LEN);
    localparam int PHYS_W = NU * URAM_WIDTH;

    generate
        if (DIN_LEN <= 0 || (DATA_LEN % DIN_LEN) != 0) begin : g_bad_din
            $error("uram_wide_banked: DATA_LEN must be a multiple of DIN_LEN");
        end
        if (NUM_BANKS < 1) begin : g_bad_banks
            $error("uram_wide_banked: NUM_BANKS must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    wr_state_e             state_q;
    logic [BANK_W-1:0]     bank_q;
    logic [ADDR_LEN-1:0]   addr_q;
    logic [DATA_LEN-1:0]   row_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [ADDR_LEN:0]     rows_q;
    logic                  ovf_q;
    logic                  done_q;
    logic                  last_q;   // row being committed closes the burst

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bank_q  <= '0;
            addr_q  <= '0;
            row_q   <= '0;
            beat_q  <= '0;
            rows_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.wr_start) begin
                        state_q <= ST_FILL;
                        bank_q  <= bus.wr_bank;
                        addr_q  <= bus.wr_base_addr;
                        rows_q  <= '0;
                        ovf_q   <= 1'b0;
                        row_q   <= '0;
                        beat_q  <= '0;
                        last_q  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (bus.din_valid) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (beat_q == BEAT_W'(k)) begin
                                row_q[k*DIN_LEN +: DIN_LEN] <= bus.din;
                            end
                        end
                        if (beat_q == BEAT_W'(BEATS-1) || bus.din_last) begin
                            state_q <= ST_COMMIT;
                            last_q  <= bus.din_last;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                end
                ST_COMMIT: begin
                    // Clearing the buffer here is what zero-pads a short
                    // final row.
                    row_q  <= '0;
                    beat_q <= '0;
                    addr_q <= addr_q + ADDR_LEN'(1);
                    rows_q <= rows_q + (ADDR_LEN+1)'(1);
                    if (&addr_q) begin
                        ovf_q <= 1'b1;
                    end
                    if (last_q) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_FILL;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.din_ready   = (state_q == ST_FILL);
    assign bus.wr_busy     = (state_q != ST_IDLE);
    assign bus.wr_done     = done_q;
    assign bus.wr_overflow = ovf_q;
    assign bus.wr_rows     = rows_q;
    assign dbg_state_o     = state_q;

    // Row widened to the primitive-aligned width; the pad bits stay zero.
    logic [PHYS_W-1:0] wdata_phys;
    always_comb begin
        wdata_phys                = '0;
        wdata_phys[DATA_LEN-1:0]  = row_q;
    end

    // ------------------------------------------------------------------
    // Read request and banks
    // ------------------------------------------------------------------
    logic [NUM_BANKS-1:0] rd_hit;     // rd_bank names an existing bank
    logic                 rd_accept;
    logic [PHYS_W-1:0]    bank_rdata [NUM_BANKS];

    // Only a commit to the very bank being read can collide.
    assign bus.rd_ready = !((state_q == ST_COMMIT) && (bus.rd_bank == bank_q));
    assign rd_accept    = bus.rd_en && bus.rd_ready;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic              we;
        logic              re;
        logic [PHYS_W-1:0] rdata;

        // An out-of-range wr_bank matches no bank, so the commit is dropped.
        assign we        = (state_q == ST_COMMIT) && (bank_q == BANK_W'(b));
        assign rd_hit[b] = (bus.rd_bank == BANK_W'(b));
        assign re        = rd_accept && rd_hit[b];

        for (genvar u = 0; u < NU; u++) begin : g_uram
            uram #(
                .ADDR_LEN (ADDR_LEN),
                .WIDTH    (URAM_WIDTH)
            ) u_uram (
                .clk     (clk),
                .we_i    (we),
                .waddr_i (addr_q),
                .wdata_i (wdata_phys[u*URAM_WIDTH +: URAM_WIDTH]),
                .re_i    (re),
                .raddr_i (bus.rd_addr),
                .rdata_o (rdata[u*URAM_WIDTH +: URAM_WIDTH])
            );
        end

        assign bank_rdata[b] = rdata;
    end

    // Stage 1 is the URAM output register; stage 2 selects the bank and
    // holds the result until the next valid read.
    logic                 rd_v1_q;
    logic [BANK_W-1:0]    rd_bank1_q;
    logic [DATA_LEN-1:0]  dout_q;
    logic [DATA_LEN-1:0]  dout_d;
    logic                 dout_valid_q;

    always_comb begin
        dout_d = dout_q;
        if (rd_v1_q) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (rd_bank1_q == BANK_W'(b)) begin
                    dout_d = bank_rdata[b][DATA_LEN-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1_q      <= 1'b0;
            rd_bank1_q   <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            rd_v1_q      <= rd_accept && (|rd_hit);
            if (rd_accept) begin
                rd_bank1_q <= bus.rd_bank;
            end
            dout_valid_q <= rd_v1_q;
            dout_q       <= dout_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_uram_wide_banked.sv
// Directed bench for uram_wide_banked with a row model and a read
// scoreboard (expected data plus expected arrival cycle).
module tb_uram_wide_banked;
    import uram_pkg::*;

    localparam int AW    = 9;
    localparam int DW    = 144;
    localparam int IW    = 8;
    localparam int NB    = 2;
    localparam int BW    = 1;
    localparam int BEATS = DW / IW;

    logic      clk;
    logic      rst_n;
    wr_state_e dbg_state;

    uram_wide_banked_if #(.ADDR_LEN(AW), .DATA_LEN(DW), .DIN_LEN(IW), .NUM_BANKS(NB)) bus ();

    uram_wide_banked #(
        .ADDR_LEN  (AW),
        .DATA_LEN  (DW),
        .DIN_LEN   (IW),
        .NUM_BANKS (NB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [DW-1:0] model [NB][1<<AW];
    int            exp_rows;
    logic          exp_ovf;
    int            done_cnt = 0;
    int            done_base;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.wr_done) done_cnt++;
    end

    always @(negedge clk) begin
        if (rst_n && bus.dout_valid) begin
            if (exp_q.size() == 0) begin
                chk("dout_valid_unexpected", DW'(bus.dout_valid), DW'(0));
            end else begin
                logic [DW-1:0] e;
                int ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk("dout", bus.dout, e);
                chk("dout_latency", DW'(cyc), DW'(ec));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_burst(input logic [BW-1:0] b, input logic [AW-1:0] base);
        bus.wr_start     = 1'b1;
        bus.wr_bank      = b;
        bus.wr_base_addr = base;
        @(negedge clk);
        bus.wr_start = 1'b0;
        exp_rows  = 0;
        exp_ovf   = 1'b0;
        done_base = done_cnt;
        chk("wr_busy_after_start", DW'(bus.wr_busy), DW'(1));
        chk("din_ready_in_fill", DW'(bus.din_ready), DW'(1));
        chk("wr_overflow_cleared", DW'(bus.wr_overflow), DW'(0));
    endtask

    task automatic send_burst(input logic [BW-1:0] b, input logic [AW-1:0] base,
                              input int n, input logic [7:0] first, input bit end_last);
        logic [DW-1:0] row;
        logic [AW-1:0] a;
        int k;
        int g;
        row = '0;
        k   = 0;
        a   = base;
        for (int i = 0; i < n; i++) begin
            bus.din       = first + 8'(i);
            bus.din_valid = 1'b1;
            bus.din_last  = end_last && (i == n-1);
            g = 0;
            while (!bus.din_ready && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (g >= 20) chk("din_ready_timeout", DW'(bus.din_ready), DW'(1));
            @(negedge clk);
            row[k*IW +: IW] = first + 8'(i);
            k++;
            if (k == BEATS || (end_last && i == n-1)) begin
                model[b][a] = row;
                row = '0;
                k   = 0;
                if (a == '1) exp_ovf = 1'b1;
                a = a + AW'(1);
                exp_rows++;
            end
        end
        bus.din_valid = 1'b0;
        bus.din_last  = 1'b0;
    endtask

    task automatic finish_burst();
        int g;
        g = 0;
        while (bus.wr_busy && g < 50) begin
            @(negedge clk);
            g++;
        end
        #1;
        chk("wr_busy_end", DW'(bus.wr_busy), DW'(0));
        chk("wr_rows", DW'(bus.wr_rows), DW'(exp_rows));
        chk("wr_overflow", DW'(bus.wr_overflow), DW'(exp_ovf));
        chk("wr_done_pulses", DW'(done_cnt - done_base), DW'(1));
        chk("din_ready_idle", DW'(bus.din_ready), DW'(0));
    endtask

    task automatic do_read(input logic [BW-1:0] b, input logic [AW-1:0] a, output int waited);
        int g;
        g = 0;
        bus.rd_en   = 1'b1;
        bus.rd_bank = b;
        bus.rd_addr = a;
        #1;
        while (!bus.rd_ready && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        waited = g;
        if (bus.rd_ready) begin
            exp_q.push_back(model[b][a]);
            exp_cyc_q.push_back(cyc + 2);
        end else begin
            chk("rd_ready_timeout", DW'(bus.rd_ready), DW'(1));
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int g;
        bus.rd_en = 1'b0;
        g = 0;
        while (exp_q.size() > 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        #1;
        chk("scoreboard_drain", DW'(exp_q.size()), DW'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_din_ready"}, DW'(bus.din_ready), DW'(0));
        chk({tag, "_wr_busy"}, DW'(bus.wr_busy), DW'(0));
        chk({tag, "_wr_done"}, DW'(bus.wr_done), DW'(0));
        chk({tag, "_wr_overflow"}, DW'(bus.wr_overflow), DW'(0));
        chk({tag, "_wr_rows"}, DW'(bus.wr_rows), DW'(0));
        chk({tag, "_dout_valid"}, DW'(bus.dout_valid), DW'(0));
        chk({tag, "_dout"}, bus.dout, DW'(0));
        chk({tag, "_rd_ready"}, DW'(bus.rd_ready), DW'(1));
        chk({tag, "_state"}, DW'(dbg_state), DW'(ST_IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        int g;
        rst_n            = 1'b0;
        bus.wr_start     = 1'b0;
        bus.wr_bank      = '0;
        bus.wr_base_addr = '0;
        bus.din          = '0;
        bus.din_valid    = 1'b0;
        bus.din_last     = 1'b0;
        bus.rd_en        = 1'b0;
        bus.rd_bank      = '0;
        bus.rd_addr      = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Two full rows into bank 0 from address 0.
        start_burst(1'b0, 9'd0);
        send_burst(1'b0, 9'd0, 36, 8'h01, 1'b1);
        finish_burst();
        do_read(1'b0, 9'd0, w);
        do_read(1'b0, 9'd1, w);
        drain();
        repeat (3) @(negedge clk);
        chk("dout_hold", bus.dout, model[0][1]);
        chk("dout_valid_idle", DW'(bus.dout_valid), DW'(0));

        // Short burst: one zero-padded row.
        start_burst(1'b1, 9'd5);
        send_burst(1'b1, 9'd5, 5, 8'hA1, 1'b1);
        finish_burst();
        do_read(1'b1, 9'd5, w);
        drain();

        // Address wrap from the top row.
        start_burst(1'b1, 9'd511);
        send_burst(1'b1, 9'd511, 36, 8'h30, 1'b1);
        finish_burst();
        repeat (5) @(negedge clk);
        chk("wr_overflow_sticky", DW'(bus.wr_overflow), DW'(1));
        do_read(1'b1, 9'd511, w);
        do_read(1'b1, 9'd0, w);
        drain();

        // Back-to-back reads of bank 1 while bank 0 fills.
        start_burst(1'b0, 9'd20);
        fork
            send_burst(1'b0, 9'd20, 36, 8'h60, 1'b1);
            begin
                for (int i = 0; i < 40; i++) begin
                    do_read(1'b1, (i % 3 == 0) ? 9'd5 : ((i % 3 == 1) ? 9'd511 : 9'd0), w);
                    chk("rd_ready_other_bank", DW'(w), DW'(0));
                end
                bus.rd_en = 1'b0;
            end
        join
        finish_burst();
        drain();

        // Read of the bank under commit must stall for that cycle.
        start_burst(1'b0, 9'd40);
        fork
            send_burst(1'b0, 9'd40, 18, 8'h90, 1'b1);
            begin
                g = 0;
                while (dbg_state != ST_COMMIT && g < 60) begin
                    @(negedge clk);
                    g++;
                end
                chk("commit_seen", DW'(dbg_state), DW'(ST_COMMIT));
                bus.rd_en   = 1'b1;
                bus.rd_bank = 1'b0;
                bus.rd_addr = 9'd0;
                #1;
                chk("rd_ready_commit_same_bank", DW'(bus.rd_ready), DW'(0));
                do_read(1'b0, 9'd0, w);
                chk("rd_stall_cycles", DW'(w), DW'(1));
                bus.rd_en = 1'b0;
            end
        join
        finish_burst();
        drain();

        // wr_start during FILL aimed at bank 1 row 5 must be ignored.
        start_burst(1'b0, 9'd10);
        fork
            send_burst(1'b0, 9'd10, 18, 8'hC0, 1'b1);
            begin
                repeat (5) @(negedge clk);
                bus.wr_start     = 1'b1;
                bus.wr_bank      = 1'b1;
                bus.wr_base_addr = 9'd5;
                @(negedge clk);
                bus.wr_start = 1'b0;
            end
        join
        finish_burst();
        do_read(1'b0, 9'd10, w);
        do_read(1'b1, 9'd5, w);
        do_read(1'b0, 9'd40, w);
        do_read(1'b0, 9'd21, w);
        drain();

        // Reset 10 beats into row 1: row 0 is new, row 1 keeps old data.
        start_burst(1'b0, 9'd0);
        send_burst(1'b0, 9'd0, 28, 8'h40, 1'b0);
        chk("mid_burst_state", DW'(dbg_state), DW'(ST_FILL));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(1'b0, 9'd0, w);
        do_read(1'b0, 9'd1, w);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
